// File: rtl/event_dispatch.sv
// rtl/event_dispatch.sv - priority-queue head dispatcher with optimism window and output FIFO
// Pops in-window events from the queue head into a small FIFO that feeds the cores.
module event_dispatch #(
    parameter int WIDTH   = 32,
    parameter int CMP_WID = 16,
    parameter int WINDOW  = 256,
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   pq_data,
    input  logic               pq_empty,
    output logic               pq_deq,
    input  logic [CMP_WID-1:0] gvt,
    input  logic               gvt_valid,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic               throttled,
    output logic [31:0]        disp_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_THROTTLE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_throttled;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_cnt;
    logic [31:0]        r_disp_cnt;

    logic [CMP_WID-1:0] w_diff;
    logic               w_in_win;
    logic               w_fifo_full;
    logic               w_push;
    logic               w_pop;

    // Modular distance handles ts/gvt wrap; a set MSB means the event is behind gvt.
    assign w_diff      = pq_data[CMP_WID-1:0] - gvt;
    assign w_in_win    = (w_diff < CMP_WID'(WINDOW)) | w_diff[CMP_WID-1];
    assign w_fifo_full = (r_cnt == FULL_CNT);

    assign w_push = (r_state != S_IDLE) & gvt_valid & ~pq_empty & w_in_win & ~w_fifo_full;
    assign w_pop  = (r_cnt != '0) & out_ready;

    assign pq_deq    = w_push & ~rst;
    assign out_valid = (r_cnt != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign throttled = r_throttled;
    assign disp_cnt  = r_disp_cnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (gvt_valid) w_state_nxt = S_RUN;
            S_RUN:      if (~pq_empty & ~w_in_win) w_state_nxt = S_THROTTLE;
            S_THROTTLE: if (w_in_win | pq_empty) w_state_nxt = S_RUN;
            default:    w_state_nxt = S_IDLE;
        endcase
        if (!gvt_valid) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_throttled <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_throttled <= (w_state_nxt == S_THROTTLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_disp_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= pq_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_disp_cnt <= r_disp_cnt + 32'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_event_dispatch.sv
// tb/tb_event_dispatch.sv - scoreboard bench for event_dispatch
module tb_event_dispatch;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pq_data;
    logic        pq_empty;
    logic        pq_deq;
    logic [15:0] gvt;
    logic        gvt_valid;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        throttled;
    logic [31:0] disp_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_deq    = 0;
    int base;

    logic [31:0] pq_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [31:0] model_tmp;
    logic        take;

    always #5 clk = ~clk;

    event_dispatch dut (
        .clk(clk), .rst(rst), .pq_data(pq_data), .pq_empty(pq_empty), .pq_deq(pq_deq),
        .gvt(gvt), .gvt_valid(gvt_valid), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .throttled(throttled), .disp_cnt(disp_cnt)
    );

    task automatic refresh();
        pq_empty = (pq_q.size() == 0);
        pq_data  = pq_empty ? 32'd0 : pq_q[0];
    endtask

    task automatic load(input logic [31:0] ev, input bit exp_it);
        pq_q.push_back(ev);
        if (exp_it) exp_q.push_back(ev);
        refresh();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (!(pq_q.size() == 0 && exp_q.size() == 0 && !out_valid) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Queue model: the head leaves the queue on the edge where pq_deq is high.
    always @(posedge clk) begin
        take = pq_deq & ~rst;
        if (take) n_deq++;
        #1;
        if (take && pq_q.size() != 0) begin
            model_tmp = pq_q.pop_front();
            refresh();
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL out_extra: got %h expected none", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    n_errors++;
                    $display("FAIL out_data: got %h expected %h", out_data, mon_exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; gvt = 16'h0; gvt_valid = 1'b0; out_ready = 1'b0;
        refresh();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pq_deq", {31'd0, pq_deq}, 32'd0);
        chk("rst_throttled", {31'd0, throttled}, 32'd0);
        chk("rst_disp_cnt", disp_cnt, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst = 1'b0;

        // 1: basic latency
        gvt = 16'h0010; gvt_valid = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        load(32'h0001_0020, 1'b1);
        #1 chk("t1_deq", {31'd0, pq_deq}, 32'd1);
        @(negedge clk);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_data", out_data, 32'h0001_0020);
        @(negedge clk);
        chk("t1_disp_cnt", disp_cnt, 32'd1);

        // 2: diff == WINDOW throttles, one step of gvt opens it
        load(32'h0002_0110, 1'b1);
        #1 chk("t2_deq_blocked", {31'd0, pq_deq}, 32'd0);
        @(negedge clk);
        chk("t2_throttled", {31'd0, throttled}, 32'd1);
        chk("t2_deq_still", {31'd0, pq_deq}, 32'd0);
        gvt = 16'h0011;
        #1 chk("t2_deq_open", {31'd0, pq_deq}, 32'd1);
        @(negedge clk);
        chk("t2_unthrottled", {31'd0, throttled}, 32'd0);
        wait_drain();
        chk("t2_disp_cnt", disp_cnt, 32'd2);

        // 3: wrap-around and straggler
        gvt = 16'hFFF0;
        base = n_deq;
        load(32'h0003_0050, 1'b1);
        load(32'h0004_FF00, 1'b1);
        #1 chk("t3_deq", {31'd0, pq_deq}, 32'd1);
        wait_drain();
        chk("t3_pops", n_deq - base, 32'd2);
        chk("t3_disp_cnt", disp_cnt, 32'd4);

        // 4: backpressure fills the FIFO, then drains in order
        gvt = 16'h0100; out_ready = 1'b0;
        base = n_deq;
        for (int i = 0; i < 6; i++) load({16'(5 + i), 16'(16'h0100 + i)}, 1'b1);
        repeat (8) @(negedge clk);
        chk("t4_pops_full", n_deq - base, 32'd4);
        chk("t4_hold_data", out_data, 32'h0005_0100);
        chk("t4_deq_full", {31'd0, pq_deq}, 32'd0);
        out_ready = 1'b1;
        wait_drain();
        chk("t4_pops_all", n_deq - base, 32'd6);
        chk("t4_disp_cnt", disp_cnt, 32'd10);

        // 5: full FIFO blocks the pop even when the core accepts
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) load({16'(16'h11 + i), 16'(16'h0110 + i)}, 1'b1);
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
        #1 chk("t5_deq_full", {31'd0, pq_deq}, 32'd0);
        @(negedge clk);
        chk("t5_deq_next", {31'd0, pq_deq}, 32'd1);
        wait_drain();
        chk("t5_disp_cnt", disp_cnt, 32'd15);

        // 6: reset discards FIFO contents; no pops until gvt_valid returns
        out_ready = 1'b0; gvt = 16'h0200;
        for (int i = 0; i < 3; i++) load({16'(16'h20 + i), 16'(16'h0200 + i)}, 1'b0);
        repeat (5) @(negedge clk);
        chk("t6_valid_pre", {31'd0, out_valid}, 32'd1);
        chk("t6_data_pre", out_data, 32'h0020_0200);
        load(32'h0023_0203, 1'b0);
        #1 chk("t6_deq_pre", {31'd0, pq_deq}, 32'd1);
        rst = 1'b1; gvt_valid = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_deq", {31'd0, pq_deq}, 32'd0);
        chk("t6_rst_disp", disp_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        base = n_deq;
        repeat (4) @(negedge clk);
        chk("t6_no_pop", n_deq - base, 32'd0);
        chk("t6_no_valid", {31'd0, out_valid}, 32'd0);
        exp_q.push_back(32'h0023_0203);
        gvt_valid = 1'b1;
        wait_drain();
        chk("t6_pop_after", n_deq - base, 32'd1);
        chk("t6_disp_cnt", disp_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
